// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for one shared FIFO write port
//
// Purpose: shares the write port of a single synchronous FIFO among N producers.
// One producer owns the port at a time for up to BURST writes. Ownership is
// released when the burst completes or the owner drops valid. The next owner is
// chosen round-robin starting after the previous owner. A one-cycle IDLE bubble
// precedes every grant. The FIFO full flag gates every write.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset; also blocks transfers combinationally
//   req_valid   per-requester valid
//   req_data    requester i data in bits [i*DW +: DW]
//   req_ready   one-hot (or zero) accept strobe to the current owner
//   fifo_full   FIFO full flag, used without lookahead
//   fifo_w_en   FIFO write enable
//   fifo_data   FIFO write data (owner's data in GRANT, zero in IDLE)
//   grant_valid high while a requester owns the port
//   grant_id    current owner index, zero when idle
module fifo_wr_arbiter #(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int BURST = 4,
  localparam int IW   = (N > 1) ? $clog2(N) : 1,
  localparam int CW   = (BURST > 1) ? $clog2(BURST) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    req_ready,
  input  logic            fifo_full,
  output logic            fifo_w_en,
  output logic [DW-1:0]   fifo_data,
  output logic            grant_valid,
  output logic [IW-1:0]   grant_id
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          owner_valid;
  logic          xfer;
  logic          found;
  logic [IW-1:0] pick;
  logic [IW:0]   scan;
  logic [IW-1:0] owner_next;

  // Round-robin pick: first valid requester at rr_ptr, rr_ptr+1, ... wrapping at N.
  // The extra bit in scan keeps the wrap correct when N is not a power of two.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    scan  = '0;
    for (int k = 0; k < N; k++) begin
      scan = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (scan >= (IW+1)'(N)) begin
        scan = scan - (IW+1)'(N);
      end
      if (!found && req_valid[scan[IW-1:0]]) begin
        found = 1'b1;
        pick  = scan[IW-1:0];
      end
    end
  end

  assign owner_next = (owner_q == IW'(N-1)) ? '0 : owner_q + 1'b1;

  // Datapath outputs. rst_n is folded into xfer so a reset cycle never writes,
  // even though the state register still shows GRANT until the edge.
  always_comb begin
    owner_valid = req_valid[owner_q];
    grant_valid = (state_q == S_GRANT);
    xfer        = grant_valid && owner_valid && !fifo_full && rst_n;
    fifo_w_en   = xfer;
    req_ready   = xfer ? (N'(1) << owner_q) : '0;
    fifo_data   = grant_valid ? req_data[owner_q*DW +: DW] : '0;
    grant_id    = grant_valid ? owner_q : '0;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_GRANT;
          owner_d = pick;
          cnt_d   = '0;
        end
      end
      S_GRANT: begin
        if (xfer && (cnt_q != CW'(BURST-1))) begin
          cnt_d = cnt_q + 1'b1;
        end else if (xfer || !owner_valid) begin
          // Burst complete, or owner dropped valid and forfeits the rest.
          state_d  = S_IDLE;
          rr_ptr_d = owner_next;
          cnt_d    = '0;
        end
        // Otherwise owner is valid but FIFO is full: hold everything.
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int BURST = 4;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_w_en;
  logic [DW-1:0]   fifo_data;
  logic            grant_valid;
  logic [1:0]      grant_id;

  fifo_wr_arbiter #(.N(N), .DW(DW), .BURST(BURST)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_w_en  (fifo_w_en),
    .fifo_data  (fifo_data),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Producer word buffers (circular), per-requester enables, FIFO full control.
  logic [DW-1:0] pbuf [N][256];
  int            phead [N];
  int            pcnt  [N];
  logic [N-1:0]  en;
  logic          full_now;

  // Reference model: who owns the port, how many writes remain in the burst,
  // and where the next round-robin search starts.
  logic m_busy;
  int   m_owner;
  int   m_left;
  int   m_ptr;

  // Per-cycle records: {grant_valid, grant_id, w_en, ready, data}.
  logic [15:0]   obs_v [$];
  logic [15:0]   exp_v [$];
  logic          wen_q [$];
  logic [DW-1:0] wlog  [$];
  int            obs_g [$];
  logic          prev_gv;

  task automatic push(input int i, input logic [DW-1:0] d);
    pbuf[i][(phead[i] + pcnt[i]) % 256] = d;
    pcnt[i]++;
  endtask

  task automatic step(input logic rst_in);
    logic [N-1:0]  v;
    logic          ex;
    logic [DW-1:0] ew;
    logic [15:0]   ev;
    logic [15:0]   ov;
    @(negedge clk);
    rst_n     = rst_in;
    fifo_full = full_now;
    for (int i = 0; i < N; i++) begin
      v[i] = en[i] && (pcnt[i] > 0);
      req_data[i*DW +: DW] = v[i] ? pbuf[i][phead[i]] : DW'($urandom);
    end
    req_valid = v;
    #1;
    ex = rst_in && m_busy && v[m_owner] && !full_now;
    ew = ex ? pbuf[m_owner][phead[m_owner]] : '0;
    ev = {m_busy, m_busy ? 2'(m_owner) : 2'd0, ex, ex ? 4'(1 << m_owner) : 4'd0, ew};
    ov = {grant_valid, grant_id, fifo_w_en, req_ready,
          (fifo_w_en || !grant_valid) ? fifo_data : 8'h00};
    exp_v.push_back(ev);
    obs_v.push_back(ov);
    wen_q.push_back(fifo_w_en);
    if (grant_valid && !prev_gv) obs_g.push_back(int'(grant_id));
    prev_gv = grant_valid;
    if (fifo_w_en) wlog.push_back(fifo_data);
    for (int i = 0; i < N; i++) begin
      if (v[i] && req_ready[i]) begin
        phead[i] = (phead[i] + 1) % 256;
        pcnt[i]--;
      end
    end
    // Advance the model to the state after the coming rising edge.
    if (!rst_in) begin
      m_busy = 1'b0; m_ptr = 0; m_owner = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        if (!m_busy && v[(m_ptr + k) % N]) begin
          m_busy = 1'b1; m_owner = (m_ptr + k) % N; m_left = BURST;
        end
      end
    end else if (ex) begin
      m_left--;
      if (m_left == 0) begin m_busy = 1'b0; m_ptr = (m_owner + 1) % N; end
    end else if (!v[m_owner]) begin
      m_busy = 1'b0; m_ptr = (m_owner + 1) % N;
    end
  endtask

  task automatic clear_and_reset();
    for (int i = 0; i < N; i++) begin
      phead[i] = 0; pcnt[i] = 0;
    end
    en = '0;
    full_now = 1'b0;
    step(1'b0);
    obs_v.delete(); exp_v.delete(); wen_q.delete(); wlog.delete(); obs_g.delete();
  endtask

  task automatic test_reset();
    m_busy = 1'b0; m_owner = 0; m_left = 0; m_ptr = 0; prev_gv = 1'b0;
    en = '0; full_now = 1'b0;
    for (int i = 0; i < N; i++) begin phead[i] = 0; pcnt[i] = 0; end
    step(1'b0);
    step(1'b0);
    step(1'b1);
    checks++;
    if ({grant_valid, grant_id, fifo_w_en, req_ready, fifo_data} !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: got gv=%b id=%0d wen=%b rdy=%b data=%h, expected all zero",
               grant_valid, grant_id, fifo_w_en, req_ready, fifo_data);
    end
  endtask

  task automatic test_single_burst();
    logic [8:0] pat;
    clear_and_reset();
    for (int k = 0; k < 6; k++) push(0, 8'h10 + 8'(k));
    en[0] = 1'b1;
    for (int c = 0; c < 9; c++) step(1'b1);
    for (int c = 0; c < obs_v.size(); c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c]) begin
        errors++;
        $display("FAIL single_model cycle %0d: got %h expected %h", c, obs_v[c], exp_v[c]);
      end
    end
    pat = 9'b011011110;
    for (int c = 0; c < 9; c++) begin
      checks++;
      if (wen_q[c] !== pat[c]) begin
        errors++;
        $display("FAIL single_wen_pattern cycle %0d: got %b expected %b", c, wen_q[c], pat[c]);
      end
    end
    checks++;
    if (wlog.size() != 6) begin
      errors++;
      $display("FAIL single_drain_count: got %0d expected 6", wlog.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (wlog[k] !== 8'h10 + 8'(k)) begin
          errors++;
          $display("FAIL single_drain word %0d: got %h expected %h", k, wlog[k], 8'h10 + 8'(k));
        end
      end
    end
  endtask

  task automatic test_all_requesters();
    int writes;
    int eg [5];
    clear_and_reset();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 32; k++) push(i, {4'(i), 4'(k)});
    en = '1;
    for (int c = 0; c < 25; c++) step(1'b1);
    for (int c = 0; c < obs_v.size(); c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c]) begin
        errors++;
        $display("FAIL all_model cycle %0d: got %h expected %h", c, obs_v[c], exp_v[c]);
      end
    end
    writes = 0;
    for (int c = 0; c < 20; c++) writes += int'(wen_q[c]);
    checks++;
    if (writes != 16) begin
      errors++;
      $display("FAIL all_writes_in_20: got %0d expected 16", writes);
    end
    eg = '{0, 1, 2, 3, 0};
    checks++;
    if (obs_g.size() < 5) begin
      errors++;
      $display("FAIL all_grant_count: got %0d expected >=5", obs_g.size());
    end else begin
      for (int g = 0; g < 5; g++) begin
        checks++;
        if (obs_g[g] != eg[g]) begin
          errors++;
          $display("FAIL all_grant_order %0d: got %0d expected %0d", g, obs_g[g], eg[g]);
        end
      end
    end
  endtask

  task automatic test_full_stall();
    logic [9:0] pat;
    clear_and_reset();
    for (int k = 0; k < 4; k++) push(1, 8'hA0 + 8'(k));
    en[1] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      full_now = (c >= 3 && c <= 5);
      step(1'b1);
    end
    full_now = 1'b0;
    for (int c = 0; c < obs_v.size(); c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c]) begin
        errors++;
        $display("FAIL stall_model cycle %0d: got %h expected %h", c, obs_v[c], exp_v[c]);
      end
    end
    pat = 10'b0011000110;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (wen_q[c] !== pat[c]) begin
        errors++;
        $display("FAIL stall_wen_pattern cycle %0d: got %b expected %b", c, wen_q[c], pat[c]);
      end
    end
    for (int c = 3; c <= 5; c++) begin
      checks++;
      if (obs_v[c][15:13] !== 3'b101) begin
        errors++;
        $display("FAIL stall_grant_held cycle %0d: got gv/id=%b expected 101", c, obs_v[c][15:13]);
      end
    end
    checks++;
    if (wlog.size() != 4) begin
      errors++;
      $display("FAIL stall_word_count: got %0d expected 4", wlog.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (wlog[k] !== 8'hA0 + 8'(k)) begin
          errors++;
          $display("FAIL stall_word %0d: got %h expected %h", k, wlog[k], 8'hA0 + 8'(k));
        end
      end
    end
  endtask

  task automatic test_drop_valid();
    int eg [5];
    clear_and_reset();
    push(2, 8'h20); push(2, 8'h21);
    en[2] = 1'b1;
    for (int c = 0; c < 18; c++) begin
      if (c == 1) begin
        push(3, 8'h30); push(0, 8'h40); push(1, 8'h50);
        en = '1;
      end
      if (c == 4) push(2, 8'h22);
      step(1'b1);
    end
    for (int c = 0; c < obs_v.size(); c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c]) begin
        errors++;
        $display("FAIL drop_model cycle %0d: got %h expected %h", c, obs_v[c], exp_v[c]);
      end
    end
    eg = '{2, 3, 0, 1, 2};
    checks++;
    if (obs_g.size() != 5) begin
      errors++;
      $display("FAIL drop_grant_count: got %0d expected 5", obs_g.size());
    end else begin
      for (int g = 0; g < 5; g++) begin
        checks++;
        if (obs_g[g] != eg[g]) begin
          errors++;
          $display("FAIL drop_grant_order %0d: got %0d expected %0d", g, obs_g[g], eg[g]);
        end
      end
    end
  endtask

  task automatic test_fairness();
    int eg [3];
    clear_and_reset();
    push(0, 8'h01);
    en[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        push(0, 8'h02); push(2, 8'h03);
        en[2] = 1'b1;
      end
      step(1'b1);
    end
    for (int c = 0; c < obs_v.size(); c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c]) begin
        errors++;
        $display("FAIL fair_model cycle %0d: got %h expected %h", c, obs_v[c], exp_v[c]);
      end
    end
    eg = '{0, 2, 0};
    checks++;
    if (obs_g.size() != 3) begin
      errors++;
      $display("FAIL fair_grant_count: got %0d expected 3", obs_g.size());
    end else begin
      for (int g = 0; g < 3; g++) begin
        checks++;
        if (obs_g[g] != eg[g]) begin
          errors++;
          $display("FAIL fair_grant_order %0d: got %0d expected %0d", g, obs_g[g], eg[g]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    clear_and_reset();
    for (int k = 0; k < 6; k++) push(3, 8'h60 + 8'(k));
    push(0, 8'h70); push(0, 8'h71);
    en[3] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c == 4) en[0] = 1'b1;
      step(c != 3);
    end
    for (int c = 0; c < obs_v.size(); c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c]) begin
        errors++;
        $display("FAIL rstmid_model cycle %0d: got %h expected %h", c, obs_v[c], exp_v[c]);
      end
    end
    checks++;
    if (wen_q[3] !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_wen_in_reset: got %b expected 0", wen_q[3]);
    end
    checks++;
    if (obs_v[4][15] !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_idle_after: got gv=%b expected 0", obs_v[4][15]);
    end
    checks++;
    if (obs_g.size() != 2 || obs_g[0] != 3 || obs_g[1] != 0) begin
      errors++;
      $display("FAIL rstmid_grants: got size=%0d first=%0d last=%0d expected 3 then 0",
               obs_g.size(), obs_g.size() > 0 ? obs_g[0] : -1,
               obs_g.size() > 0 ? obs_g[obs_g.size()-1] : -1);
    end
  endtask

  task automatic test_random();
    clear_and_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) en[i] = ~en[i];
        if (pcnt[i] < 200 && $urandom_range(0, 3) == 0) push(i, DW'($urandom));
      end
      full_now = ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 99) != 0);
    end
    full_now = 1'b0;
    for (int c = 0; c < obs_v.size(); c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c]) begin
        errors++;
        $display("FAIL random_model cycle %0d: got %h expected %h", c, obs_v[c], exp_v[c]);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    test_reset();
    test_single_burst();
    test_all_requesters();
    test_full_stall();
    test_drop_valid();
    test_fairness();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
